load_store_unit: RTL and testbench

Memory-side initiator for the MIPS datapath. It accepts one load or store request at a time from the execute/memory stage and drives the byte-addressed, big-endian data memory's `wr_mem`/`rd_mem`/`addr`/`wr_data` interface. It samples `rd_data` and returns extended load data or a store acknowledge. Byte and halfword stores are done as read-modify-write, because the memory always writes four bytes.

---
 rtl/load_store_unit.sv | 172 +++++++++++++++++
 tb/tb_load_store_unit.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Load/store initiator for a big-endian, word-wide data memory.
// Sub-word stores are performed as read-modify-write of the containing word.
module load_store_unit #(
    parameter int unsigned ADDR_LIMIT = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        wr_mem,
    output logic        rd_mem,
    output logic [31:0] addr,
    output logic [31:0] wr_data,
    input  logic [31:0] rd_data
);

    typedef enum logic [2:0] {
        IDLE, RD, RDW, WR, ERR, RESP
    } state_t;

    state_t      state, state_n;
    logic        accept;
    logic        req_err;
    logic [31:0] req_waddr;

    logic        lat_we;
    logic        lat_signed;
    logic [1:0]  lat_size;
    logic [31:0] lat_addr;
    logic [15:0] lat_wdata;

    logic [7:0]  rd_byte;
    logic [15:0] rd_half;
    logic [31:0] load_val;
    logic [31:0] merged;

    logic        rd_mem_d, wr_mem_d, resp_valid_d, resp_err_d;
    logic [31:0] addr_d, wr_data_d, resp_rdata_d;

    assign req_ready = (state == IDLE) & ~rst;
    assign accept    = req_valid & req_ready;
    assign req_waddr = {req_addr[31:2], 2'b00};

    assign req_err = (req_size == 2'd3)
                   | ((req_size == 2'd1) & req_addr[0])
                   | ((req_size == 2'd2) & (|req_addr[1:0]))
                   | (req_waddr > 32'(ADDR_LIMIT - 4));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lat_we     <= 1'b0;
            lat_signed <= 1'b0;
            lat_size   <= 2'd0;
            lat_addr   <= 32'd0;
            lat_wdata  <= 16'd0;
        end else if (accept) begin
            lat_we     <= req_we;
            lat_signed <= req_signed;
            lat_size   <= req_size;
            lat_addr   <= req_addr;
            lat_wdata  <= req_wdata[15:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    if (req_err)
                        state_n = ERR;
                    else if (req_we && (req_size == 2'd2))
                        state_n = WR;
                    else
                        state_n = RD;
                end
            end
            RD:      state_n = RDW;
            RDW:     state_n = lat_we ? WR : RESP;
            WR:      state_n = RESP;
            ERR:     state_n = IDLE;
            RESP:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Big-endian lane select: offset 0 is the most significant byte.
    always_comb begin
        rd_byte = 8'd0;
        unique case (lat_addr[1:0])
            2'd0: rd_byte = rd_data[31:24];
            2'd1: rd_byte = rd_data[23:16];
            2'd2: rd_byte = rd_data[15:8];
            2'd3: rd_byte = rd_data[7:0];
            default: rd_byte = 8'd0;
        endcase
        rd_half = lat_addr[1] ? rd_data[15:0] : rd_data[31:16];

        unique case (lat_size)
            2'd0:    load_val = {{24{lat_signed & rd_byte[7]}}, rd_byte};
            2'd1:    load_val = {{16{lat_signed & rd_half[15]}}, rd_half};
            default: load_val = rd_data;
        endcase

        merged = rd_data;
        if (lat_size == 2'd0) begin
            unique case (lat_addr[1:0])
                2'd0: merged[31:24] = lat_wdata[7:0];
                2'd1: merged[23:16] = lat_wdata[7:0];
                2'd2: merged[15:8]  = lat_wdata[7:0];
                2'd3: merged[7:0]   = lat_wdata[7:0];
                default: merged = rd_data;
            endcase
        end else if (lat_addr[1]) begin
            merged[15:0] = lat_wdata;
        end else begin
            merged[31:16] = lat_wdata;
        end
    end

    // Outputs are computed for the upcoming state and registered.
    always_comb begin
        rd_mem_d     = (state_n == RD);
        wr_mem_d     = (state_n == WR);
        addr_d       = 32'd0;
        wr_data_d    = 32'd0;
        resp_valid_d = (state_n == RESP) || (state_n == ERR);
        resp_err_d   = (state_n == ERR);
        resp_rdata_d = 32'd0;
        if (rd_mem_d || wr_mem_d)
            addr_d = (state == IDLE) ? req_waddr
                                     : {lat_addr[31:2], 2'b00};
        if (wr_mem_d)
            wr_data_d = (state == IDLE) ? req_wdata : merged;
        if ((state_n == RESP) && (state == RDW) && !lat_we)
            resp_rdata_d = load_val;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_mem     <= 1'b0;
            wr_mem     <= 1'b0;
            addr       <= 32'd0;
            wr_data    <= 32'd0;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= 32'd0;
        end else begin
            rd_mem     <= rd_mem_d;
            wr_mem     <= wr_mem_d;
            addr       <= addr_d;
            wr_data    <= wr_data_d;
            resp_valid <= resp_valid_d;
            resp_err   <= resp_err_d;
            resp_rdata <= resp_rdata_d;
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit with a registered big-endian memory model.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_we, req_signed;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_err, wr_mem, rd_mem;
    logic [31:0] resp_rdata, addr, wr_data;
    logic [31:0] rd_data = 32'd0;

    logic [31:0] mem [0:255];

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        int          cyc;
    } rsp_t;

    typedef struct {
        logic        wr;
        logic [31:0] a;
        logic [31:0] d;
        int          cyc;
    } stb_t;

    rsp_t rsp_q[$];
    stb_t stb_q[$];

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int last_acc = 0;

    load_store_unit #(.ADDR_LIMIT(1024)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_size(req_size),
        .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_err(resp_err),
        .wr_mem(wr_mem), .rd_mem(rd_mem),
        .addr(addr), .wr_data(wr_data), .rd_data(rd_data)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (wr_mem) mem[addr[9:2]] <= wr_data;
        if (rd_mem) rd_data <= mem[addr[9:2]];
    end

    function automatic void chk(input string nm,
                                input logic [31:0] act,
                                input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)",
                     nm, act, exp, cyc);
        end
    endfunction

    // Response monitor
    always @(negedge clk) begin
        if (!rst) begin
            if (resp_valid) begin
                if (rsp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL resp_unexpected: got resp_valid=1 expected 0 (cycle %0d)", cyc);
                end else begin
                    rsp_t r;
                    r = rsp_q.pop_front();
                    chk("resp_err", {31'd0, resp_err}, {31'd0, r.err});
                    chk("resp_rdata", resp_rdata, r.rdata);
                    chk("resp_cycle", cyc, r.cyc);
                end
            end else begin
                chk("resp_idle_zero", resp_rdata | {31'd0, resp_err}, 32'd0);
            end
        end
    end

    // Strobe monitor
    always @(negedge clk) begin
        if (!rst) begin
            if (rd_mem && wr_mem) begin
                checks++;
                failures++;
                $display("FAIL strobe_overlap: got rd_mem=1 wr_mem=1 expected exclusive (cycle %0d)", cyc);
            end else if (rd_mem || wr_mem) begin
                if (stb_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL strobe_unexpected: got rd=%b wr=%b addr=%h expected none (cycle %0d)",
                             rd_mem, wr_mem, addr, cyc);
                end else begin
                    stb_t s;
                    s = stb_q.pop_front();
                    chk("strobe_kind", {31'd0, wr_mem}, {31'd0, s.wr});
                    chk("strobe_addr", addr, s.a);
                    chk("strobe_wdata", wr_data, s.d);
                    chk("strobe_cycle", cyc, s.cyc);
                end
            end else begin
                chk("bus_quiet_zero", addr | wr_data, 32'd0);
            end
        end
    end

    task automatic issue(input logic we, input logic [1:0] sz,
                         input logic sg, input logic [31:0] a,
                         input logic [31:0] wd, input logic err,
                         input logic [31:0] exp_rd,
                         input logic [31:0] exp_wd,
                         input bit hold, input int exp_acc);
        int n;
        int lat;
        logic [31:0] wa;
        req_valid  = 1'b1;
        req_we     = we;
        req_size   = sz;
        req_signed = sg;
        req_addr   = a;
        req_wdata  = wd;
        #1;
        n = 0;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!req_ready) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout: got req_ready=0 expected 1 within 50 cycles");
            req_valid = 1'b0;
            return;
        end
        wa = {a[31:2], 2'b00};
        if (err)                 lat = 1;
        else if (!we)            lat = 3;
        else if (sz == 2'd2)     lat = 2;
        else                     lat = 4;
        if (!err) begin
            if (we && sz == 2'd2) begin
                stb_q.push_back('{1'b1, wa, wd, cyc + 1});
            end else begin
                stb_q.push_back('{1'b0, wa, 32'd0, cyc + 1});
                if (we) stb_q.push_back('{1'b1, wa, exp_wd, cyc + 3});
            end
        end
        rsp_q.push_back('{err, exp_rd, cyc + lat});
        if (exp_acc >= 0) chk("b2b_accept_cycle", cyc, exp_acc);
        last_acc = cyc;
        @(posedge clk);
        @(negedge clk);
        if (!hold) req_valid = 1'b0;
    endtask

    task automatic ld(input logic [31:0] a, input logic [1:0] sz,
                      input logic sg, input logic [31:0] exp);
        issue(1'b0, sz, sg, a, 32'd0, 1'b0, exp, 32'd0, 1'b0, -1);
    endtask

    task automatic st(input logic [31:0] a, input logic [1:0] sz,
                      input logic [31:0] wd, input logic [31:0] exp_wd);
        issue(1'b1, sz, 1'b0, a, wd, 1'b0, 32'd0, exp_wd, 1'b0, -1);
    endtask

    task automatic er(input logic we, input logic [1:0] sz,
                      input logic [31:0] a);
        issue(we, sz, 1'b0, a, 32'hA5A5A5A5, 1'b1, 32'd0, 32'd0, 1'b0, -1);
    endtask

    initial begin
        int n;
        for (int i = 0; i < 256; i++) mem[i] = 32'd0;
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_size   = 2'd0;
        req_signed = 1'b0;
        req_addr   = 32'd0;
        req_wdata  = 32'd0;
        repeat (3) @(negedge clk);
        chk("rst_strobes", {30'd0, rd_mem, wr_mem}, 32'd0);
        chk("rst_resp", {31'd0, resp_valid}, 32'd0);
        chk("rst_addr", addr | wr_data | resp_rdata, 32'd0);
        rst = 1'b0;
        #1;
        chk("rst_ready", {31'd0, req_ready}, 32'd1);
        @(negedge clk);

        // word store then load
        st(32'h10, 2'd2, 32'h11223344, 32'h11223344);
        ld(32'h10, 2'd2, 1'b0, 32'h11223344);

        // sub-word loads
        st(32'h10, 2'd2, 32'h1180FF44, 32'h1180FF44);
        ld(32'h11, 2'd0, 1'b1, 32'hFFFFFF80);
        ld(32'h11, 2'd0, 1'b0, 32'h00000080);
        ld(32'h12, 2'd1, 1'b1, 32'hFFFFFF44);
        ld(32'h12, 2'd1, 1'b0, 32'h0000FF44);
        ld(32'h10, 2'd0, 1'b0, 32'h00000011);
        ld(32'h10, 2'd1, 1'b1, 32'h00001180);

        // read-modify-write stores
        st(32'h10, 2'd2, 32'h11223344, 32'h11223344);
        st(32'h13, 2'd0, 32'hFFFFFFAB, 32'h112233AB);
        st(32'h10, 2'd1, 32'h1234BEEF, 32'hBEEF33AB);
        ld(32'h10, 2'd2, 1'b0, 32'hBEEF33AB);
        st(32'h11, 2'd0, 32'h00000077, 32'hBE7733AB);
        ld(32'h10, 2'd2, 1'b0, 32'hBE7733AB);

        // errors
        er(1'b0, 2'd2, 32'h12);
        er(1'b0, 2'd1, 32'h11);
        er(1'b0, 2'd3, 32'h10);
        er(1'b0, 2'd2, 32'h3FD);
        er(1'b0, 2'd2, 32'h400);
        er(1'b1, 2'd0, 32'h400);
        st(32'h3FC, 2'd2, 32'hCAFEF00D, 32'hCAFEF00D);
        ld(32'h3FC, 2'd2, 1'b0, 32'hCAFEF00D);

        // reset in the middle of a byte store
        st(32'h10, 2'd2, 32'h11223344, 32'h11223344);
        st(32'h13, 2'd0, 32'h000000AB, 32'h112233AB);
        @(negedge clk);
        rst = 1'b1;
        stb_q.delete();
        rsp_q.delete();
        #1;
        chk("midrst_strobes", {30'd0, rd_mem, wr_mem}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("midrst_ready", {31'd0, req_ready}, 32'd1);
        @(negedge clk);
        ld(32'h10, 2'd2, 1'b0, 32'h11223344);

        // back-to-back with req_valid held
        issue(1'b0, 2'd2, 1'b0, 32'h10, 32'd0, 1'b0,
              32'h11223344, 32'd0, 1'b1, -1);
        issue(1'b1, 2'd2, 1'b0, 32'h20, 32'h55667788, 1'b0,
              32'd0, 32'd0, 1'b0, last_acc + 4);
        ld(32'h20, 2'd2, 1'b0, 32'h55667788);

        n = 0;
        while ((rsp_q.size() != 0 || stb_q.size() != 0) && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (rsp_q.size() != 0 || stb_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain: got %0d responses and %0d strobes pending expected 0",
                     rsp_q.size(), stb_q.size());
        end
        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
